// File: rtl/step_sequencer_if.sv
// Control/status bundle between the debug/stall sources and step_sequencer.
// master drives the controls; slave is the sequencer side.
interface step_sequencer_if #(
    parameter int COUNT_WIDTH = 16
);
    logic                   start;
    logic                   stall_req;
    logic                   halt_req;
    logic                   resume;
    logic                   single_step;
    logic [1:0]             current_step;
    logic [3:0]             step_onehot;
    logic                   running;
    logic                   stalled;
    logic                   halted;
    logic                   instr_done;
    logic [COUNT_WIDTH-1:0] retired_count;

    modport master (
        output start, stall_req, halt_req, resume, single_step,
        input  current_step, step_onehot, running, stalled, halted,
        input  instr_done, retired_count
    );

    modport slave (
        input  start, stall_req, halt_req, resume, single_step,
        output current_step, step_onehot, running, stalled, halted,
        output instr_done, retired_count
    );
endinterface

// File: rtl/step_sequencer.sv
// Instruction step sequencer with stall hold and run/halt/single-step control.
// Optional retired-instruction counter: define STEP_SEQ_RETIRE_COUNT_EN.
module step_sequencer #(
    parameter int LAST_STEP   = 3,
    parameter int COUNT_WIDTH = 16
) (
    input logic              clock,
    input logic              async_reset,
    step_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, STALL, HALT} state_t;

    localparam logic [1:0] LAST = 2'(LAST_STEP);

    state_t     state_q, state_d;
    logic [1:0] step_q, step_d;
    logic       pend_q, pend_d;
    logic       done_q, done_d;

    always_ff @(posedge clock or posedge async_reset) begin
        if (async_reset) begin
            state_q <= IDLE;
            step_q  <= 2'd0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        pend_d  = pend_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) state_d = RUN;
            end
            RUN: begin
                if (bus.stall_req) begin
                    state_d = STALL;
                end else if (step_q == LAST) begin
                    step_d = 2'd0;
                    done_d = 1'b1;
                    pend_d = 1'b0;
                    if (bus.halt_req || pend_q) state_d = HALT;
                end else begin
                    step_d = step_q + 2'd1;
                end
            end
            // Release edge only returns to RUN; the step advances one edge later
            STALL: begin
                if (!bus.stall_req) state_d = RUN;
            end
            HALT: begin
                step_d = 2'd0;
                if (bus.single_step) begin
                    state_d = RUN;
                    pend_d  = 1'b1;
                end else if (bus.resume) begin
                    state_d = RUN;
                    pend_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.current_step = step_q;
    assign bus.step_onehot  = 4'b0001 << step_q;
    assign bus.running      = (state_q == RUN) || (state_q == STALL);
    assign bus.stalled      = (state_q == STALL);
    assign bus.halted       = (state_q == HALT);
    assign bus.instr_done   = done_q;

`ifdef STEP_SEQ_RETIRE_COUNT_EN
    logic [COUNT_WIDTH-1:0] count_q;

    always_ff @(posedge clock or posedge async_reset) begin
        if (async_reset) begin
            count_q <= '0;
        end else if (done_d) begin
            count_q <= count_q + COUNT_WIDTH'(1);
        end
    end

    assign bus.retired_count = count_q;
`else
    assign bus.retired_count = '0;
`endif
endmodule

// File: tb/tb_step_sequencer.sv
// Scoreboard bench for step_sequencer: LAST_STEP=3 and LAST_STEP=1 instances
// share directed and random stimulus, checked against a behavioural model.
module tb_step_sequencer;
    localparam int CW = 16;

    logic clock = 1'b0;
    logic async_reset = 1'b1;
    logic start = 1'b0;
    logic stall_req = 1'b0;
    logic halt_req = 1'b0;
    logic resume = 1'b0;
    logic single_step = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    step_sequencer_if #(.COUNT_WIDTH(CW)) bus3 ();
    step_sequencer_if #(.COUNT_WIDTH(CW)) bus1 ();

    assign bus3.start       = start;
    assign bus3.stall_req   = stall_req;
    assign bus3.halt_req    = halt_req;
    assign bus3.resume      = resume;
    assign bus3.single_step = single_step;
    assign bus1.start       = start;
    assign bus1.stall_req   = stall_req;
    assign bus1.halt_req    = halt_req;
    assign bus1.resume      = resume;
    assign bus1.single_step = single_step;

    step_sequencer #(.LAST_STEP(3), .COUNT_WIDTH(CW)) dut3 (
        .clock(clock), .async_reset(async_reset), .bus(bus3)
    );
    step_sequencer #(.LAST_STEP(1), .COUNT_WIDTH(CW)) dut1 (
        .clock(clock), .async_reset(async_reset), .bus(bus1)
    );

    typedef struct {
        bit started; bit halted; bit frozen; bit pend; bit done;
        int step; int cnt;
    } mdl_t;

    typedef struct {
        int step; int onehot; int running; int stalled;
        int halted; int done; int cnt;
    } exp_t;

    typedef struct { exp_t a; exp_t b; } pair_t;

    pair_t sbq[$];
    mdl_t  m3 = '{default: 0};
    mdl_t  m1 = '{default: 0};

    // One clock edge of the sequencer as described by its rules.
    function automatic mdl_t advance(mdl_t s, int last, bit rst);
        mdl_t n = s;
        if (rst) return '{default: 0};
        n.done = 0;
        if (!s.started) begin
            if (start) n.started = 1;
        end else if (s.halted) begin
            if (single_step) begin
                n.halted = 0; n.pend = 1;
            end else if (resume) begin
                n.halted = 0;
            end
        end else if (s.frozen) begin
            if (!stall_req) n.frozen = 0;
        end else if (stall_req) begin
            n.frozen = 1;
        end else if (s.step == last) begin
            n.step = 0;
            n.done = 1;
            n.cnt  = (s.cnt + 1) % (1 << CW);
            if (halt_req || s.pend) n.halted = 1;
            n.pend = 0;
        end else begin
            n.step = s.step + 1;
        end
        return n;
    endfunction

    function automatic exp_t view(mdl_t s);
        exp_t e;
        e.step    = s.step;
        e.onehot  = 1 << s.step;
        e.running = int'(s.started && !s.halted);
        e.stalled = int'(s.frozen);
        e.halted  = int'(s.halted);
        e.done    = int'(s.done);
`ifdef STEP_SEQ_RETIRE_COUNT_EN
        e.cnt = s.cnt;
`else
        e.cnt = 0;
`endif
        return e;
    endfunction

    function void chk(string name, int got, int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d",
                     name, $time, got, exp);
        end
    endfunction

    function void cmp_l3(exp_t e);
        chk("l3.current_step", int'(bus3.current_step), e.step);
        chk("l3.step_onehot", int'(bus3.step_onehot), e.onehot);
        chk("l3.running", int'(bus3.running), e.running);
        chk("l3.stalled", int'(bus3.stalled), e.stalled);
        chk("l3.halted", int'(bus3.halted), e.halted);
        chk("l3.instr_done", int'(bus3.instr_done), e.done);
        chk("l3.retired_count", int'(bus3.retired_count), e.cnt);
    endfunction

    function void cmp_l1(exp_t e);
        chk("l1.current_step", int'(bus1.current_step), e.step);
        chk("l1.step_onehot", int'(bus1.step_onehot), e.onehot);
        chk("l1.running", int'(bus1.running), e.running);
        chk("l1.stalled", int'(bus1.stalled), e.stalled);
        chk("l1.halted", int'(bus1.halted), e.halted);
        chk("l1.instr_done", int'(bus1.instr_done), e.done);
        chk("l1.retired_count", int'(bus1.retired_count), e.cnt);
    endfunction

    // Model: sample inputs at each edge and queue the expected outputs.
    initial forever begin
        @(posedge clock);
        m3 = advance(m3, 3, async_reset);
        m1 = advance(m1, 1, async_reset);
        sbq.push_back('{view(m3), view(m1)});
    end

    // Monitor: outputs are presented every cycle, compared after the edge.
    initial forever begin
        pair_t p;
        @(posedge clock);
        #1;
        if (sbq.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
        end else begin
            p = sbq.pop_front();
            cmp_l3(p.a);
            cmp_l1(p.b);
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_step(int s);
        for (int i = 0; i < 40 && m3.step != s; i++) @(negedge clock);
        if (m3.step != s) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_step timeout: step %0d, wanted %0d",
                     m3.step, s);
        end
    endtask

    task automatic wait_halted();
        for (int i = 0; i < 40 && !m3.halted; i++) @(negedge clock);
        if (!m3.halted) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_halted timeout: halted %0d, wanted 1",
                     m3.halted);
        end
    endtask

    // Reset between edges must clear outputs immediately.
    task automatic mid_reset();
        #2;
        async_reset = 1'b1;
        #1;
        chk("rst.l3.current_step", int'(bus3.current_step), 0);
        chk("rst.l3.step_onehot", int'(bus3.step_onehot), 1);
        chk("rst.l3.instr_done", int'(bus3.instr_done), 0);
        chk("rst.l3.running", int'(bus3.running), 0);
        chk("rst.l3.halted", int'(bus3.halted), 0);
        chk("rst.l3.retired_count", int'(bus3.retired_count), 0);
        chk("rst.l1.current_step", int'(bus1.current_step), 0);
        chk("rst.l1.instr_done", int'(bus1.instr_done), 0);
        @(negedge clock);
        async_reset = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clock);
        async_reset = 1'b0;
        @(negedge clock);

        pulse_start();
        repeat (44) @(negedge clock);

        wait_step(1);
        stall_req = 1'b1;
        repeat (3) @(negedge clock);
        stall_req = 1'b0;
        repeat (6) @(negedge clock);

        wait_step(1);
        halt_req = 1'b1;
        stall_req = 1'b1;
        repeat (2) @(negedge clock);
        stall_req = 1'b0;
        wait_halted();
        halt_req = 1'b0;
        stall_req = 1'b1;
        repeat (20) @(negedge clock);
        stall_req = 1'b0;
        resume = 1'b1;
        @(negedge clock);
        resume = 1'b0;
        repeat (6) @(negedge clock);

        halt_req = 1'b1;
        wait_halted();
        halt_req = 1'b0;
        repeat (3) @(negedge clock);
        single_step = 1'b1;
        @(negedge clock);
        single_step = 1'b0;
        repeat (8) @(negedge clock);
        single_step = 1'b1;
        resume = 1'b1;
        @(negedge clock);
        single_step = 1'b0;
        resume = 1'b0;
        repeat (8) @(negedge clock);
        resume = 1'b1;
        @(negedge clock);
        resume = 1'b0;

        wait_step(2);
        mid_reset();
        repeat (3) @(negedge clock);

        for (int i = 0; i < 3000; i++) begin
            start       = ($urandom % 8) == 0;
            resume      = ($urandom % 5) == 0;
            single_step = ($urandom % 6) == 0;
            if (($urandom % 6) == 0) stall_req = ~stall_req;
            if (($urandom % 10) == 0) halt_req = ~halt_req;
            if (($urandom % 400) == 0) mid_reset();
            else @(negedge clock);
        end

        start = 1'b0;
        stall_req = 1'b0;
        halt_req = 1'b0;
        resume = 1'b0;
        single_step = 1'b0;
        repeat (3) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
